// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter family: count mode and sizing helper.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled clock cycles by PRESCALE; tick marks the last enabled cycle of each period.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int            PW   = clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;
  logic          w_last;

  assign w_last = (r_pre == LAST);
  assign tick   = en && w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (restart) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= w_last ? '0 : r_pre + PW'(1);
    end
  end

endmodule

// File: rtl/modulo_counter.sv
// Parametrised up/down modulo counter with prescaler, load/clear, wrap or saturate,
// and a registered terminal-count pulse.
module modulo_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam count_mode_e      MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] r_value;
  logic             r_tc;
  logic             w_tick;
  logic             w_restart;
  logic             w_at_bound;
  logic [WIDTH-1:0] w_step_value;
  logic [WIDTH-1:0] w_load_value;

  assign w_restart = clear | load;

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .restart(w_restart),
    .tick   (w_tick)
  );

  assign w_at_bound   = up ? (r_value == MAX) : (r_value == '0);
  assign w_load_value = (load_value > MAX) ? MAX : load_value;

  always_comb begin
    w_step_value = r_value;
    if (!w_at_bound) begin
      w_step_value = up ? r_value + WIDTH'(1) : r_value - WIDTH'(1);
    end else if (MODE == MODE_WRAP) begin
      w_step_value = up ? '0 : MAX;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
      r_tc    <= 1'b0;
    end else if (clear) begin
      r_value <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_value <= w_load_value;
      r_tc    <= 1'b0;
    end else if (w_tick) begin
      r_value <= w_step_value;
      r_tc    <= w_at_bound;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  assign value = r_value;
  assign tc    = r_tc;

endmodule
